spi_apb_regif: RTL
==================

// Module: spi_apb_regif
// PURPOSE
//  APB slave register/FIFO front-end sitting directly upstream of spi_master on Pclk.
//  Buffers CPU TX bytes in a TX FIFO and launches one spi_master transfer per byte.
//  Captures each received byte into an RX FIFO and raises a level interrupt.
//  Drives spi_master's clk_div, mode, write_data, write_en and enable.
// PARAMETERS
//  FIFO_DEPTH  8   entries per TX/RX FIFO; power of 2, >=2
//  DATA_W      8   SPI byte width; must match spi_master write_data/read_data
//  ADDR_W      5   APB address width
// PORTS
//  Pclk        in   1        single clock for the whole block
//  Preset      in   1        reset; synchronous, active-high
//  Psel        in   1        APB select
//  Penable     in   1        APB access phase
//  Pwrite      in   1        1=write, 0=read
//  Paddr       in   ADDR_W   byte address
//  Pwdata      in   32       write data
//  Prdata      out  32       read data; valid in access phase
//  Pready      out  1        tied 1; zero wait states
//  Pslverr     out  1        error response; valid in access phase
//  clk_div     out  6        to spi_master; CTRL.CLK_DIV
//  mode        out  2        to spi_master; CTRL.MODE (CPOL,CPHA)
//  enable      out  1        to spi_master; CTRL.EN
//  write_data  out  DATA_W   to spi_master; TX byte, stable while write_en=1
//  write_en    out  1        to spi_master; one-cycle launch pulse
//  read_data   in   DATA_W   from spi_master; valid when busy falls
//  busy        in   1        from spi_master; high during a transfer
//  irq         out  1        level interrupt = |(IRQ_EN & {rx_ovf, !rx_empty, tx_empty})
// BEHAVIOUR
//  Reset: all regs 0, FIFOs empty, FSM=IDLE; Prdata=0, Pslverr=0, write_en=0, enable=0,
//   mode=0, clk_div=0, write_data=0, irq=0. Preset mid-transfer aborts FSM, flushes FIFOs.
//  APB access = Psel&Penable; action taken in that cycle; Prdata/Pslverr combinational.
//  Map: 0x00 CTRL RW [0]EN [2:1]MODE [8:3]CLK_DIV; 0x04 STATUS RO/W1C [0]tx_full
//   [1]tx_empty [2]rx_full [3]rx_empty [4]active [5]rx_ovf(sticky, W1C);
//   0x08 TXDATA WO push [7:0]; 0x0C RXDATA RO pop [7:0]; 0x10 IRQ_EN RW [2:0].
//  Pslverr=1 (no state change): TXDATA write when tx_full; RXDATA read when rx_empty
//   (Prdata=0); CTRL write while FSM!=IDLE; unmapped address. Reads of WO -> 0.
//  FSM IDLE: EN=1 & !tx_empty & !busy -> LAUNCH (pop TX; register byte to write_data).
//   LAUNCH: write_en=1 exactly one cycle -> WAIT_BUSY.
//   WAIT_BUSY: busy=1 -> WAIT_DONE. WAIT_DONE: busy 1->0 -> push read_data to RX -> IDLE.
//  Throughput: min 1 idle cycle between transfers; launch latency 2 Pclk from TX push.
//  RX full at completion: byte dropped, rx_ovf set; same-cycle APB RXDATA pop frees slot
//   first (byte kept). TX full with same-cycle launch pop: APB push accepted.
//  FIFO simultaneous push+pop: both occur, count unchanged; pointers wrap mod FIFO_DEPTH.
//  EN cleared mid-transfer: current byte completes and is captured; no further launches.
//  STATUS.active = FSM!=IDLE. W1C on rx_ovf same cycle as new overflow: stays set.
// STRUCTURE
//  spi_pkg: register offset localparams, STATUS/CTRL bit indices, FSM state enum
//   (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE).
//  Sub-module sync_fifo #(DEPTH, WIDTH): instantiated twice (TX, RX); count-based full/empty.
// TESTING
//  1 Reset: Preset=1 3 cycles -> STATUS=0x0A, all outputs 0, irq=0.
//  2 CTRL=0x0F(EN=1,MODE=3,DIV=1), TXDATA=0x40 -> write_en one pulse, write_data=0x40;
//    model busy 20 cycles, read_data=0xA5 -> RXDATA read returns 0xA5, rx_empty=1 after.
//  3 Push 9 bytes back-to-back (EN=0) -> 9th Pslverr=1, tx_full=1; EN=1 -> 8 in-order launches.
//  4 RX full (8 unread) + one more transfer -> rx_ovf=1, IRQ_EN=4 -> irq=1; W1C 0x20 clears.
//  5 RXDATA read when empty -> Pslverr=1, Prdata=0; CTRL write while active -> Pslverr=1.
//  6 Preset asserted in WAIT_DONE -> FSM IDLE, FIFOs empty, write_en=0 next cycle.

Source files
------------

// File: rtl/spi_apb_regif_pkg.sv
// Shared definitions for the SPI APB register front-end: register offsets,
// register bit positions and the transfer-sequencer state encoding.
package spi_apb_regif_pkg;

    // Register byte offsets
    localparam int OFS_CTRL   = 'h00;
    localparam int OFS_STATUS = 'h04;
    localparam int OFS_TXDATA = 'h08;
    localparam int OFS_RXDATA = 'h0C;
    localparam int OFS_IRQ_EN = 'h10;

    // CTRL field positions
    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_DIV_LSB  = 3;

    // STATUS bit positions
    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_ACTIVE   = 4;
    localparam int ST_RX_OVF   = 5;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/spi_apb_regif_sync_fifo.sv
// Count-based synchronous FIFO with first-word fall-through read port.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module spi_apb_regif_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push & ~do_pop)
                count <= count + (AW+1)'(1);
            else if (do_pop & ~do_push)
                count <= count - (AW+1)'(1);
        end
    end

    // Storage array; slot contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/spi_apb_regif.sv
// APB register/FIFO front-end for spi_master: buffers TX bytes, launches one
// SPI transfer per byte, captures received bytes and raises a level interrupt.
module spi_apb_regif
    import spi_apb_regif_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 5
) (
    input  logic              Pclk,
    input  logic              Preset,
    input  logic              Psel,
    input  logic              Penable,
    input  logic              Pwrite,
    input  logic [ADDR_W-1:0] Paddr,
    input  logic [31:0]       Pwdata,
    output logic [31:0]       Prdata,
    output logic              Pready,
    output logic              Pslverr,
    output logic [5:0]        clk_div,
    output logic [1:0]        mode,
    output logic              enable,
    output logic [DATA_W-1:0] write_data,
    output logic              write_en,
    input  logic [DATA_W-1:0] read_data,
    input  logic              busy,
    output logic              irq
);

    fsm_state_t        state;
    logic [2:0]        irq_en;
    logic              rx_ovf;
    logic              access, wr, rd, idle;
    logic              sel_ctrl, sel_status, sel_txdata, sel_rxdata, sel_irq, mapped;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [DATA_W-1:0] tx_rdata, rx_rdata;
    logic              launch, done;
    logic              tx_push, tx_pop, tx_reject;
    logic              rx_push, rx_pop, rx_drop;
    logic              unused_pwdata;

    assign access = Psel & Penable;
    assign wr     = access & Pwrite;
    assign rd     = access & ~Pwrite;
    assign idle   = (state == IDLE);

    assign sel_ctrl   = (Paddr == ADDR_W'(OFS_CTRL));
    assign sel_status = (Paddr == ADDR_W'(OFS_STATUS));
    assign sel_txdata = (Paddr == ADDR_W'(OFS_TXDATA));
    assign sel_rxdata = (Paddr == ADDR_W'(OFS_RXDATA));
    assign sel_irq    = (Paddr == ADDR_W'(OFS_IRQ_EN));
    assign mapped     = sel_ctrl | sel_status | sel_txdata | sel_rxdata | sel_irq;

    // A launch pop frees a TX slot in the same cycle, so a push to a full FIFO
    // is only rejected when no launch is happening.
    assign launch    = idle & enable & ~tx_empty & ~busy;
    assign tx_pop    = launch;
    assign tx_reject = tx_full & ~tx_pop;
    assign tx_push   = wr & sel_txdata & ~tx_reject;

    // A CPU pop in the completion cycle frees the slot before the new byte lands.
    assign done    = (state == WAIT_DONE) & ~busy;
    assign rx_pop  = rd & sel_rxdata & ~rx_empty;
    assign rx_push = done & (~rx_full | rx_pop);
    assign rx_drop = done & rx_full & ~rx_pop;

    assign Pready  = 1'b1;
    assign Pslverr = access & (~mapped
                             | (Pwrite  & sel_txdata & tx_reject)
                             | (~Pwrite & sel_rxdata & rx_empty)
                             | (Pwrite  & sel_ctrl   & ~idle));

    assign irq = |(irq_en & {rx_ovf, ~rx_empty, tx_empty});

    assign unused_pwdata = ^Pwdata[31:9];

    spi_apb_regif_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
        .clk   (Pclk),
        .rst   (Preset),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (Pwdata[DATA_W-1:0]),
        .rdata (tx_rdata),
        .full  (tx_full),
        .empty (tx_empty)
    );

    spi_apb_regif_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
        .clk   (Pclk),
        .rst   (Preset),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (read_data),
        .rdata (rx_rdata),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Read-data mux; zero outside a read access and for erroring/write-only reads.
    always_comb begin
        Prdata = '0;
        if (rd) begin
            if (sel_ctrl) begin
                Prdata[CTRL_EN]             = enable;
                Prdata[CTRL_MODE_LSB +: 2]  = mode;
                Prdata[CTRL_DIV_LSB +: 6]   = clk_div;
            end else if (sel_status) begin
                Prdata[ST_TX_FULL]  = tx_full;
                Prdata[ST_TX_EMPTY] = tx_empty;
                Prdata[ST_RX_FULL]  = rx_full;
                Prdata[ST_RX_EMPTY] = rx_empty;
                Prdata[ST_ACTIVE]   = ~idle;
                Prdata[ST_RX_OVF]   = rx_ovf;
            end else if (sel_rxdata && !rx_empty) begin
                Prdata = 32'(rx_rdata);
            end else if (sel_irq) begin
                Prdata = 32'(irq_en);
            end
        end
    end

    // Control/config registers; CTRL is frozen while a transfer is in flight.
    always_ff @(posedge Pclk) begin
        if (Preset) begin
            enable  <= 1'b0;
            mode    <= '0;
            clk_div <= '0;
            irq_en  <= '0;
            rx_ovf  <= 1'b0;
        end else begin
            if (wr && sel_ctrl && idle) begin
                enable  <= Pwdata[CTRL_EN];
                mode    <= Pwdata[CTRL_MODE_LSB +: 2];
                clk_div <= Pwdata[CTRL_DIV_LSB +: 6];
            end
            if (wr && sel_irq) irq_en <= Pwdata[2:0];
            // A new overflow wins over a simultaneous write-1-to-clear.
            if (rx_drop)
                rx_ovf <= 1'b1;
            else if (wr && sel_status && Pwdata[ST_RX_OVF])
                rx_ovf <= 1'b0;
        end
    end

    // Transfer sequencer: pop a byte, pulse write_en once, follow busy to completion.
    always_ff @(posedge Pclk) begin
        if (Preset) begin
            state      <= IDLE;
            write_en   <= 1'b0;
            write_data <= '0;
        end else begin
            write_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state      <= LAUNCH;
                        write_en   <= 1'b1;
                        write_data <= tx_rdata;
                    end
                end
                LAUNCH:    state <= WAIT_BUSY;
                WAIT_BUSY: if (busy) state <= WAIT_DONE;
                WAIT_DONE: if (!busy) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule
